// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage: ALU, branch-target add and destination select, registered into EX/MEM with stall/flush
module execute_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] nPC,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] SE,
    input  logic [4:0]   RT,
    input  logic [4:0]   RD,
    input  logic [1:0]   ALUOp,
    input  logic         ALUSrc,
    input  logic         Branch,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic         MemtoReg,
    input  logic         RegWrite,
    input  logic         RegDst,
    output logic [W-1:0] BTA,
    output logic         Zero,
    output logic [W-1:0] ALUResult,
    output logic [W-1:0] StoreData,
    output logic [4:0]   WriteReg,
    output logic         Branch_out,
    output logic         MemRead_out,
    output logic         MemWrite_out,
    output logic         MemtoReg_out,
    output logic         RegWrite_out
);
    typedef enum logic [2:0] {OpAdd, OpSub, OpAnd, OpOr, OpNor, OpSlt, OpNone} aluCtl_t;
    aluCtl_t ctl;
    logic [W-1:0] opB, resultD, btaD;
    logic [4:0] writeRegD;
    logic [5:0] funct;
    always_comb begin
        funct = SE[5:0];
        opB = ALUSrc ? SE : B;
        writeRegD = RegDst ? RD : RT;
        btaD = nPC + (SE << 2);
        ctl = (ALUOp == 2'b01) ? OpSub :
              (ALUOp != 2'b10) ? OpAdd :
              (funct == 6'h20) ? OpAdd :
              (funct == 6'h22) ? OpSub :
              (funct == 6'h24) ? OpAnd :
              (funct == 6'h25) ? OpOr  :
              (funct == 6'h27) ? OpNor :
              (funct == 6'h2A) ? OpSlt : OpNone;
        resultD = (ctl == OpAdd) ? A + opB :
                  (ctl == OpSub) ? A - opB :
                  (ctl == OpAnd) ? A & opB :
                  (ctl == OpOr)  ? A | opB :
                  (ctl == OpNor) ? ~(A | opB) :
                  (ctl == OpSlt) ? {{(W-1){1'b0}}, $signed(A) < $signed(opB)} : '0;
    end
    // flush overrides stall: data still advances, control becomes a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BTA          <= '0;
            Zero         <= 1'b0;
            ALUResult    <= '0;
            StoreData    <= '0;
            WriteReg     <= '0;
            Branch_out   <= 1'b0;
            MemRead_out  <= 1'b0;
            MemWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
        end else if (flush || !stall) begin
            BTA          <= btaD;
            Zero         <= resultD == '0;
            ALUResult    <= resultD;
            StoreData    <= B;
            WriteReg     <= writeRegD;
            Branch_out   <= !flush && Branch;
            MemRead_out  <= !flush && MemRead;
            MemWrite_out <= !flush && MemWrite;
            MemtoReg_out <= !flush && MemtoReg;
            RegWrite_out <= !flush && RegWrite && ctl != OpNone;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized scoreboard bench for execute_stage against an arithmetic reference model
module tb_execute_stage;
    localparam int W = 32;
    typedef struct packed {
        logic [W-1:0] bta;
        logic         zero;
        logic [W-1:0] alu;
        logic [W-1:0] sd;
        logic [4:0]   wr;
        logic         br, mr, mw, mtr, rw;
    } exMem_t;

    logic clk = 1'b0, reset = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [W-1:0] nPC = '0, A = '0, B = '0, SE = '0;
    logic [4:0] RT = '0, RD = '0;
    logic [1:0] ALUOp = '0;
    logic ALUSrc = 0, Branch = 0, MemRead = 0, MemWrite = 0, MemtoReg = 0, RegWrite = 0, RegDst = 0;
    logic [W-1:0] BTA, ALUResult, StoreData;
    logic [4:0] WriteReg;
    logic Zero, Branch_out, MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out;

    execute_stage #(.W(W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .nPC(nPC), .A(A), .B(B), .SE(SE),
        .RT(RT), .RD(RD), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .BTA(BTA), .Zero(Zero), .ALUResult(ALUResult), .StoreData(StoreData), .WriteReg(WriteReg),
        .Branch_out(Branch_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out)
    );

    always #5 clk = ~clk;

    exMem_t got, cur;
    exMem_t expQ[$];
    int tests = 0, fails = 0;
    assign got = '{BTA, Zero, ALUResult, StoreData, WriteReg, Branch_out, MemRead_out,
                   MemWrite_out, MemtoReg_out, RegWrite_out};

    function automatic exMem_t model();
        exMem_t e;
        logic [W-1:0] b2, r;
        logic known;
        b2 = ALUSrc ? SE : B;
        known = 1'b1;
        r = '0;
        case (ALUOp)
            2'b00, 2'b11: r = A + b2;
            2'b01:        r = A - b2;
            default: case (SE[5:0])
                6'h20: r = A + b2;
                6'h22: r = A - b2;
                6'h24: r = A & b2;
                6'h25: r = A | b2;
                6'h27: r = ~(A | b2);
                6'h2A: r = ($signed(A) < $signed(b2)) ? 1 : 0;
                default: known = 1'b0;
            endcase
        endcase
        e.bta = nPC + SE * 4;
        e.zero = (r == 0);
        e.alu = r;
        e.sd = B;
        e.wr = RegDst ? RD : RT;
        e.br = Branch;
        e.mr = MemRead;
        e.mw = MemWrite;
        e.mtr = MemtoReg;
        e.rw = RegWrite && known;
        return e;
    endfunction

    task automatic step();
        exMem_t n;
        n = model();
        if (flush) {n.br, n.mr, n.mw, n.mtr, n.rw} = '0;
        else if (stall) n = cur;
        cur = n;
        expQ.push_back(n);
        @(negedge clk);
    endtask

    task automatic clearIn();
        {nPC, A, B, SE, RT, RD, ALUOp} = '0;
        {ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, RegDst, stall, flush} = '0;
    endtask

    task automatic checkNow(input string name, input exMem_t e);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, e);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) checkNow("exmem", expQ.pop_front());
    end

    task automatic test1();
        clearIn();
        A = 7; B = 5; ALUOp = 2'b10; SE = 32'h22; RegDst = 1; RD = 3; RegWrite = 1;
    endtask

    initial begin
        cur = '0;
        #3 checkNow("reset_state", '0);
        @(negedge clk);
        reset = 1'b1;
        test1(); step();
        clearIn(); A = 32'h1000; SE = 32'hFFFF_FFFC; ALUSrc = 1; MemRead = 1; RT = 8; step();
        clearIn(); A = 9; B = 9; ALUOp = 2'b01; nPC = 32'h40; SE = 3; Branch = 1; step();
        clearIn(); A = 32'hFFFF_FFFF; B = 1; ALUOp = 2'b10; SE = 32'h2A; RegDst = 1; RD = 4; RegWrite = 1; step();
        SE = 32'h3F; step();
        test1(); step();
        clearIn(); A = 100; B = 1; ALUOp = 2'b10; SE = 32'h20; MemWrite = 1; stall = 1; step();
        A = 55; step();
        Branch = 1; MemtoReg = 1; RegWrite = 1; flush = 1; step();
        test1(); step();
        stall = 1; A = 1234;
        reset = 1'b0;
        #1 checkNow("async_reset", '0);
        cur = '0;
        @(negedge clk);
        checkNow("reset_hold", '0);
        reset = 1'b1; stall = 0; step();
        for (int i = 0; i < 400; i++) begin
            int f;
            nPC = $urandom; A = $urandom; SE = $urandom;
            B = ($urandom_range(0, 7) == 0) ? A : $urandom;
            if ($urandom_range(0, 3) == 0) SE = {{26{SE[31]}}, SE[5:0]};
            f = $urandom_range(0, 7);
            if (ALUOp == 2'b10 || $urandom_range(0, 1) == 0)
                SE[5:0] = (f == 0) ? 6'h20 : (f == 1) ? 6'h22 : (f == 2) ? 6'h24 :
                          (f == 3) ? 6'h25 : (f == 4) ? 6'h27 : (f == 5) ? 6'h2A : 6'($urandom);
            RT = 5'($urandom); RD = 5'($urandom); ALUOp = 2'($urandom);
            {ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite, RegDst} = 7'($urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            step();
        end
        clearIn();
        repeat (3) @(negedge clk);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain pending %0d exp 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
